// File: rtl/pacman_input_pkg.sv
// Shared types and constants for the joystick front end: heading encoding,
// button bit positions and handshake states.
package pacman_input_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    HS_IDLE    = 1'b0,
    HS_PENDING = 1'b1
  } hs_state_t;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int NUM_BTN   = 4;

  // Simultaneous presses resolve to the lowest bit index.
  function automatic dir_t press_to_dir(input logic [NUM_BTN-1:0] press);
    if (press[BTN_UP])        return DIR_UP;
    else if (press[BTN_DOWN]) return DIR_DOWN;
    else if (press[BTN_LEFT]) return DIR_LEFT;
    else                      return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Single-bit debouncer: 2-flop synchronizer, saturating stability counter,
// debounced active-high level and a one-cycle pulse on each rising edge.
module button_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= ~i_btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_TC) begin
        // Last differing cycle of the window: commit the new level now.
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_sync2;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/joystick_input_ctrl.sv
// Joystick front end: four debounced direction buttons, latched heading with
// lowest-index priority, and a request/ack handshake toward game logic.
//   state      | meaning
//   HS_IDLE    | no unconsumed heading; dir_req low
//   HS_PENDING | heading updated, waiting for dir_ack; dir_req high
module joystick_input_ctrl
  import pacman_input_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_n,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [1:0] dir,
  output logic       dir_valid,
  output logic       dir_req,
  input  logic       dir_ack
);

  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_press;
  logic               w_dir_upd;
  dir_t               w_dir_nxt;
  hs_state_t          w_state_nxt;

  dir_t               r_dir;
  logic               r_dir_valid;
  hs_state_t          r_state;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    button_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .i_clk  (clk),
      .i_reset(reset),
      .i_btn_n(btn_n[gi]),
      .o_level(w_level[gi]),
      .o_press(w_press[gi])
    );
  end

  assign w_dir_upd = |w_press;
  assign w_dir_nxt = press_to_dir(w_press);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dir       <= DIR_UP;
      r_dir_valid <= 1'b0;
      r_state     <= HS_IDLE;
    end else begin
      r_state <= w_state_nxt;
      if (w_dir_upd) begin
        r_dir       <= w_dir_nxt;
        r_dir_valid <= 1'b1;
      end
    end
  end

  // A fresh heading wins over a coincident ack so the new value is not lost.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HS_IDLE:    if (w_dir_upd) w_state_nxt = HS_PENDING;
      HS_PENDING: if (!w_dir_upd && dir_ack) w_state_nxt = HS_IDLE;
      default:    w_state_nxt = HS_IDLE;
    endcase
  end

  assign btn_level = w_level;
  assign btn_press = w_press;
  assign dir       = r_dir;
  assign dir_valid = r_dir_valid;
  assign dir_req   = (r_state == HS_PENDING);

endmodule

// File: tb/tb_joystick_input_ctrl.sv
// Self-checking bench for joystick_input_ctrl with DB_CYCLES=4: directed
// scenarios plus randomized button/ack traffic against a window-based model.
module tb_joystick_input_ctrl;
  import pacman_input_pkg::*;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_n = 4'hF;
  logic       dir_ack = 1'b0;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [1:0] dir;
  logic       dir_valid;
  logic       dir_req;

  int n_checks = 0;
  int n_fail = 0;

  joystick_input_ctrl #(.DB_CYCLES(DB)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_n    (btn_n),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .dir      (dir),
    .dir_valid(dir_valid),
    .dir_req  (dir_req),
    .dir_ack  (dir_ack)
  );

  always #5 clk = ~clk;

  // Reference model: per-bit history of sampled (inverted) inputs. The level
  // flips at an edge when every sample in the window seen through the two
  // synchronizer stages disagrees with the current level.
  logic       m_hist [4][DB+2];
  logic [3:0] m_level = '0;
  logic [3:0] m_press = '0;
  logic [1:0] m_dir = 2'd0;
  logic       m_valid = 1'b0;
  logic       m_pend = 1'b0;
  logic       m_all_diff;

  always @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 4; b++)
        for (int k = 0; k < DB + 2; k++) m_hist[b][k] = 1'b0;
      m_level = '0;
      m_press = '0;
      m_dir   = 2'd0;
      m_valid = 1'b0;
      m_pend  = 1'b0;
    end else begin
      if (m_press != 4'b0000) begin
        for (int i = 3; i >= 0; i--) if (m_press[i]) m_dir = 2'(i);
        m_valid = 1'b1;
        m_pend  = 1'b1;
      end else if (dir_ack) begin
        m_pend = 1'b0;
      end
      for (int b = 0; b < 4; b++) begin
        for (int k = DB + 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
        m_hist[b][0] = ~btn_n[b];
        m_all_diff = 1'b1;
        for (int k = 2; k <= DB + 1; k++)
          if (m_hist[b][k] == m_level[b]) m_all_diff = 1'b0;
        m_press[b] = 1'b0;
        if (m_all_diff) begin
          m_level[b] = ~m_level[b];
          m_press[b] = m_level[b];
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; btn_n = 4'hF; dir_ack = 1'b0;
    tick(3);
    n_checks++; if (btn_level !== 4'b0000) begin n_fail++; $display("FAIL reset_level: got %b expected 0000", btn_level); end
    n_checks++; if (btn_press !== 4'b0000) begin n_fail++; $display("FAIL reset_press: got %b expected 0000", btn_press); end
    n_checks++; if (dir !== DIR_UP) begin n_fail++; $display("FAIL reset_dir: got %0d expected 0", dir); end
    n_checks++; if (dir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", dir_valid); end
    n_checks++; if (dir_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", dir_req); end
  endtask

  task automatic test_clean_press;
    btn_n = 4'b1110; reset = 1'b0;
    tick(5);
    n_checks++; if (btn_level !== 4'b0000) begin n_fail++; $display("FAIL clean_early_level: got %b expected 0000", btn_level); end
    tick(1);
    n_checks++; if (btn_level !== 4'b0001) begin n_fail++; $display("FAIL clean_level: got %b expected 0001", btn_level); end
    n_checks++; if (btn_press !== 4'b0001) begin n_fail++; $display("FAIL clean_press: got %b expected 0001", btn_press); end
    n_checks++; if (dir_req !== 1'b0) begin n_fail++; $display("FAIL clean_req_early: got %b expected 0", dir_req); end
    tick(1);
    n_checks++; if (btn_press !== 4'b0000) begin n_fail++; $display("FAIL clean_press_once: got %b expected 0000", btn_press); end
    n_checks++; if (dir !== DIR_UP) begin n_fail++; $display("FAIL clean_dir: got %0d expected 0", dir); end
    n_checks++; if (dir_valid !== 1'b1) begin n_fail++; $display("FAIL clean_valid: got %b expected 1", dir_valid); end
    n_checks++; if (dir_req !== 1'b1) begin n_fail++; $display("FAIL clean_req: got %b expected 1", dir_req); end
    dir_ack = 1'b1; tick(1); dir_ack = 1'b0;
    n_checks++; if (dir_req !== 1'b0) begin n_fail++; $display("FAIL clean_ack: got %b expected 0", dir_req); end
    dir_ack = 1'b1; tick(2); dir_ack = 1'b0;
    n_checks++; if (dir_req !== 1'b0) begin n_fail++; $display("FAIL idle_ack: got %b expected 0", dir_req); end
    btn_n = 4'hF;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      n_checks++; if (btn_press !== 4'b0000) begin n_fail++; $display("FAIL release_press: got %b expected 0000", btn_press); end
    end
    n_checks++; if (btn_level !== 4'b0000) begin n_fail++; $display("FAIL release_level: got %b expected 0000", btn_level); end
    n_checks++; if (dir !== DIR_UP) begin n_fail++; $display("FAIL release_dir: got %0d expected 0", dir); end
  endtask

  task automatic test_glitch;
    btn_n = 4'b1101;
    tick(3);
    btn_n = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n_checks++; if (btn_level !== 4'b0000) begin n_fail++; $display("FAIL glitch_level: got %b expected 0000", btn_level); end
      n_checks++; if (btn_press !== 4'b0000) begin n_fail++; $display("FAIL glitch_press: got %b expected 0000", btn_press); end
      n_checks++; if (dir_req !== 1'b0) begin n_fail++; $display("FAIL glitch_req: got %b expected 0", dir_req); end
    end
    n_checks++; if (dir !== DIR_UP) begin n_fail++; $display("FAIL glitch_dir: got %0d expected 0", dir); end
  endtask

  task automatic test_simultaneous;
    btn_n = 4'b0011;
    tick(6);
    n_checks++; if (btn_press !== 4'b1100) begin n_fail++; $display("FAIL simul_press: got %b expected 1100", btn_press); end
    tick(1);
    n_checks++; if (dir !== DIR_LEFT) begin n_fail++; $display("FAIL simul_dir: got %0d expected 2", dir); end
    n_checks++; if (dir_req !== 1'b1) begin n_fail++; $display("FAIL simul_req: got %b expected 1", dir_req); end
    n_checks++; if (btn_level !== 4'b1100) begin n_fail++; $display("FAIL simul_level: got %b expected 1100", btn_level); end
    dir_ack = 1'b1; tick(1); dir_ack = 1'b0;
    n_checks++; if (dir_req !== 1'b0) begin n_fail++; $display("FAIL simul_ack: got %b expected 0", dir_req); end
    btn_n = 4'b0111;
    tick(10);
    n_checks++; if (dir !== DIR_LEFT) begin n_fail++; $display("FAIL left_release_dir: got %0d expected 2", dir); end
    n_checks++; if (btn_level !== 4'b1000) begin n_fail++; $display("FAIL left_release_level: got %b expected 1000", btn_level); end
    n_checks++; if (dir_req !== 1'b0) begin n_fail++; $display("FAIL left_release_req: got %b expected 0", dir_req); end
    btn_n = 4'hF;
    tick(8);
  endtask

  task automatic test_overwrite;
    btn_n = 4'b0111;
    tick(7);
    n_checks++; if (dir !== DIR_RIGHT) begin n_fail++; $display("FAIL ovw_right_dir: got %0d expected 3", dir); end
    n_checks++; if (dir_req !== 1'b1) begin n_fail++; $display("FAIL ovw_right_req: got %b expected 1", dir_req); end
    btn_n = 4'b0110;
    tick(7);
    n_checks++; if (dir !== DIR_UP) begin n_fail++; $display("FAIL ovw_up_dir: got %0d expected 0", dir); end
    n_checks++; if (dir_req !== 1'b1) begin n_fail++; $display("FAIL ovw_up_req: got %b expected 1", dir_req); end
    n_checks++; if (btn_level !== 4'b1001) begin n_fail++; $display("FAIL ovw_level: got %b expected 1001", btn_level); end
    dir_ack = 1'b1; tick(1); dir_ack = 1'b0;
    n_checks++; if (dir_req !== 1'b0) begin n_fail++; $display("FAIL ovw_ack: got %b expected 0", dir_req); end
    btn_n = 4'hF;
    tick(8);
  endtask

  task automatic test_ack_coincide;
    btn_n = 4'b1011;
    tick(7);
    n_checks++; if (dir !== DIR_LEFT) begin n_fail++; $display("FAIL coin_left_dir: got %0d expected 2", dir); end
    n_checks++; if (dir_req !== 1'b1) begin n_fail++; $display("FAIL coin_left_req: got %b expected 1", dir_req); end
    btn_n = 4'b1001;
    tick(6);
    n_checks++; if (btn_press !== 4'b0010) begin n_fail++; $display("FAIL coin_press: got %b expected 0010", btn_press); end
    dir_ack = 1'b1; tick(1); dir_ack = 1'b0;
    n_checks++; if (dir_req !== 1'b1) begin n_fail++; $display("FAIL coin_req: got %b expected 1", dir_req); end
    n_checks++; if (dir !== DIR_DOWN) begin n_fail++; $display("FAIL coin_dir: got %0d expected 1", dir); end
    dir_ack = 1'b1; tick(1); dir_ack = 1'b0;
    n_checks++; if (dir_req !== 1'b0) begin n_fail++; $display("FAIL coin_ack: got %b expected 0", dir_req); end
    btn_n = 4'hF;
    tick(8);
  endtask

  task automatic test_reset_mid;
    btn_n = 4'b1110;
    tick(7);
    n_checks++; if (dir_req !== 1'b1) begin n_fail++; $display("FAIL rmid_pending: got %b expected 1", dir_req); end
    btn_n = 4'b1101;
    tick(5);
    reset = 1'b1; tick(1); reset = 1'b0;
    n_checks++; if (btn_level !== 4'b0000) begin n_fail++; $display("FAIL rmid_level: got %b expected 0000", btn_level); end
    n_checks++; if (dir_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req: got %b expected 0", dir_req); end
    n_checks++; if (dir_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", dir_valid); end
    n_checks++; if (dir !== DIR_UP) begin n_fail++; $display("FAIL rmid_dir: got %0d expected 0", dir); end
    tick(5);
    n_checks++; if (btn_level !== 4'b0000) begin n_fail++; $display("FAIL rmid_early: got %b expected 0000", btn_level); end
    tick(1);
    n_checks++; if (btn_level !== 4'b0010) begin n_fail++; $display("FAIL rmid_rise: got %b expected 0010", btn_level); end
    tick(1);
    n_checks++; if (dir !== DIR_DOWN) begin n_fail++; $display("FAIL rmid_dir_after: got %0d expected 1", dir); end
    btn_n = 4'hF;
    tick(8);
  endtask

  task automatic test_random;
    int hold;
    reset = 1'b1; btn_n = 4'hF; dir_ack = 1'b0;
    tick(2);
    reset = 1'b0;
    for (int seg = 0; seg < 120; seg++) begin
      btn_n = 4'($urandom);
      hold  = $urandom_range(1, 9);
      if ($urandom_range(0, 39) == 0) reset = 1'b1;
      for (int c = 0; c < hold; c++) begin
        dir_ack = ($urandom_range(0, 3) == 0);
        tick(1);
        reset = 1'b0;
        n_checks++; if (btn_level !== m_level) begin n_fail++; $display("FAIL rnd_level: got %b expected %b", btn_level, m_level); end
        n_checks++; if (btn_press !== m_press) begin n_fail++; $display("FAIL rnd_press: got %b expected %b", btn_press, m_press); end
        n_checks++; if (dir !== m_dir) begin n_fail++; $display("FAIL rnd_dir: got %0d expected %0d", dir, m_dir); end
        n_checks++; if (dir_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid: got %b expected %b", dir_valid, m_valid); end
        n_checks++; if (dir_req !== m_pend) begin n_fail++; $display("FAIL rnd_req: got %b expected %b", dir_req, m_pend); end
      end
    end
    dir_ack = 1'b0;
    btn_n = 4'hF;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_simultaneous();
    test_overwrite();
    test_ack_coincide();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
